mtr_ramp_ctrl: RTL and testbench

Slew-rate controller that sits between the tour/command logic and `MtrDrv`, sequencing the signed 11-bit left/right speed words the driver's PWM stages consume. Targets are ramped in fixed steps once per PWM period instead of being applied instantly. Direction reversals pass through zero and dwell there. A stop input brakes both channels to zero at a faster rate.

---
 rtl/mtr_pkg.sv | 31 +++
 rtl/mtr_ramp_ctrl_if.sv | 23 ++
 rtl/spd_slew.sv | 111 +++++++++++
 rtl/mtr_ramp_ctrl.sv | 95 +++++++++
 tb/tb_mtr_ramp_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mtr_pkg.sv
// Shared types, limits and step arithmetic for the motor speed slew controller.
package mtr_pkg;

  typedef logic signed [10:0] spd_t;

  typedef enum logic [1:0] {HOLD, RAMP, DWELL, BRAKE} ramp_state_t;

  localparam spd_t SPD_MAX = 11'sd1023;
  localparam spd_t SPD_MIN = -11'sd1023;

  function automatic spd_t clamp_spd(spd_t v);
    return (v < SPD_MIN) ? SPD_MIN : ((v > SPD_MAX) ? SPD_MAX : v);
  endfunction

  // Moves cur toward aim by at most s; 12-bit math so +/-1023 differences cannot overflow.
  function automatic spd_t step_toward(spd_t cur, spd_t aim, logic signed [11:0] s);
    logic signed [11:0] c, a, d, r;
    c = {cur[10], cur};
    a = {aim[10], aim};
    d = a - c;
    if (d > s) begin
      r = c + s;
    end else if (d < -s) begin
      r = c - s;
    end else begin
      r = a;
    end
    return r[10:0];
  endfunction

endpackage

// File: rtl/mtr_ramp_ctrl_if.sv
// Command/speed bundle between the tour logic and the ramp controller.
interface mtr_ramp_ctrl_if;
  import mtr_pkg::*;

  spd_t tgt_lft;
  spd_t tgt_rght;
  logic tgt_vld;
  logic stop;
  spd_t lft_spd;
  spd_t rght_spd;
  logic busy;
  logic at_tgt;

  modport master (
    output tgt_lft, tgt_rght, tgt_vld, stop,
    input  lft_spd, rght_spd, busy, at_tgt
  );

  modport slave (
    input  tgt_lft, tgt_rght, tgt_vld, stop,
    output lft_spd, rght_spd, busy, at_tgt
  );
endinterface

// File: rtl/spd_slew.sv
// One channel of the ramp controller: HOLD/RAMP/DWELL/BRAKE FSM and step arithmetic.
// DWELL at zero on sign reversal is built only with MTR_ZERO_DWELL_EN defined.
module spd_slew
  import mtr_pkg::*;
#(
  parameter int unsigned STEP        = 32,
  parameter int unsigned BRK_STEP    = 128,
  parameter int unsigned DWELL_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        stop,
  input  spd_t        tgt,
  output spd_t        cur,
  output spd_t        cur_nxt,
  output ramp_state_t state_nxt
);

  localparam logic signed [11:0] StepS = 12'(STEP);
  localparam logic signed [11:0] BrkS  = 12'(BRK_STEP);
  localparam spd_t               Zero  = '0;

  ramp_state_t state_q, state_d;
  spd_t        cur_q, cur_d;
  spd_t        aim, step_nxt;
  logic        tgt_pos, cur_pos, rev;

`ifdef MTR_ZERO_DWELL_EN
  localparam int unsigned DwellW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  logic [DwellW-1:0] dwell_q, dwell_d;
`endif

  // Opposite nonzero signs: ramp to zero first, real target afterwards.
  assign tgt_pos  = !tgt[10] && (tgt != Zero);
  assign cur_pos  = !cur_q[10] && (cur_q != Zero);
  assign rev      = (tgt_pos && cur_q[10]) || (tgt[10] && cur_pos);
  assign aim      = rev ? Zero : tgt;
  assign step_nxt = step_toward(cur_q, aim, StepS);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
`ifdef MTR_ZERO_DWELL_EN
    dwell_d = dwell_q;
`endif
    if (stop) begin
      state_d = BRAKE;
      if (tick) cur_d = step_toward(cur_q, Zero, BrkS);
`ifdef MTR_ZERO_DWELL_EN
      dwell_d = '0;
`endif
    end else begin
      case (state_q)
        HOLD, RAMP: begin
          if (cur_q == tgt) begin
            state_d = HOLD;
          end else if (!tick) begin
            state_d = RAMP;
          end else begin
            cur_d = step_nxt;
            if (step_nxt == tgt) begin
              state_d = HOLD;
`ifdef MTR_ZERO_DWELL_EN
            end else if (rev && (step_nxt == Zero)) begin
              state_d = DWELL;
              dwell_d = '0;
`endif
            end else begin
              state_d = RAMP;
            end
          end
        end
`ifdef MTR_ZERO_DWELL_EN
        DWELL: begin
          if (tick) begin
            if ((int'(dwell_q) + 1) >= int'(DWELL_TICKS)) begin
              state_d = RAMP;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end
`endif
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      cur_q   <= '0;
`ifdef MTR_ZERO_DWELL_EN
      dwell_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
`ifdef MTR_ZERO_DWELL_EN
      dwell_q <= dwell_d;
`endif
    end
  end

  assign cur       = cur_q;
  assign cur_nxt   = cur_d;
  assign state_nxt = state_d;

endmodule

// File: rtl/mtr_ramp_ctrl.sv
// Slew-rate controller feeding MtrDrv: tick generator, target latch, stop and status flags.
// Zero-dwell on direction reversal is enabled by defining MTR_ZERO_DWELL_EN.
module mtr_ramp_ctrl
  import mtr_pkg::*;
#(
  parameter int unsigned TICK_CYC    = 2048,
  parameter int unsigned STEP        = 32,
  parameter int unsigned BRK_STEP    = 128,
  parameter int unsigned DWELL_TICKS = 4
) (
  input logic             clk,
  input logic             rst,
  mtr_ramp_ctrl_if.slave  bus
);

  localparam int unsigned CntW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;
  spd_t            tgt_lft_q, tgt_lft_d, tgt_rght_q, tgt_rght_d;
  spd_t            lft_cur, lft_nxt, rght_cur, rght_nxt;
  ramp_state_t     lft_state_nxt, rght_state_nxt;
  logic            busy_q, busy_d, at_tgt_q, at_tgt_d;

  assign tick  = (cnt_q == CntW'(TICK_CYC - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Channels see the next-state target so a strobe coincident with tick acts on that tick.
  always_comb begin
    tgt_lft_d  = tgt_lft_q;
    tgt_rght_d = tgt_rght_q;
    if (bus.stop) begin
      tgt_lft_d  = '0;
      tgt_rght_d = '0;
    end else if (bus.tgt_vld) begin
      tgt_lft_d  = clamp_spd(bus.tgt_lft);
      tgt_rght_d = clamp_spd(bus.tgt_rght);
    end
  end

  spd_slew #(
    .STEP       (STEP),
    .BRK_STEP   (BRK_STEP),
    .DWELL_TICKS(DWELL_TICKS)
  ) u_lft (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .stop     (bus.stop),
    .tgt      (tgt_lft_d),
    .cur      (lft_cur),
    .cur_nxt  (lft_nxt),
    .state_nxt(lft_state_nxt)
  );

  spd_slew #(
    .STEP       (STEP),
    .BRK_STEP   (BRK_STEP),
    .DWELL_TICKS(DWELL_TICKS)
  ) u_rght (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .stop     (bus.stop),
    .tgt      (tgt_rght_d),
    .cur      (rght_cur),
    .cur_nxt  (rght_nxt),
    .state_nxt(rght_state_nxt)
  );

  assign busy_d   = (lft_state_nxt != HOLD) || (rght_state_nxt != HOLD);
  assign at_tgt_d = !bus.stop && (lft_nxt == tgt_lft_d) && (rght_nxt == tgt_rght_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      tgt_lft_q  <= '0;
      tgt_rght_q <= '0;
      busy_q     <= 1'b0;
      at_tgt_q   <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      tgt_lft_q  <= tgt_lft_d;
      tgt_rght_q <= tgt_rght_d;
      busy_q     <= busy_d;
      at_tgt_q   <= at_tgt_d;
    end
  end

  assign bus.lft_spd  = lft_cur;
  assign bus.rght_spd = rght_cur;
  assign bus.busy     = busy_q;
  assign bus.at_tgt   = at_tgt_q;

endmodule

// File: tb/tb_mtr_ramp_ctrl.sv
// Directed bench for mtr_ramp_ctrl with a 16-cycle tick; samples once per tick period.
module tb_mtr_ramp_ctrl;
  import mtr_pkg::*;

  localparam int unsigned TickCyc = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mtr_ramp_ctrl_if bus ();

  mtr_ramp_ctrl #(
    .TICK_CYC   (TickCyc),
    .STEP       (32),
    .BRK_STEP   (128),
    .DWELL_TICKS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Every tick period is TickCyc cycles, so each window below contains exactly one tick.
  task automatic strobe(input int l, input int r);
    bus.tgt_lft  = spd_t'(l);
    bus.tgt_rght = spd_t'(r);
    bus.tgt_vld  = 1'b1;
    @(negedge clk);
    bus.tgt_vld  = 1'b0;
  endtask

  task automatic first_tick;
    repeat (TickCyc - 1) @(negedge clk);
  endtask

  task automatic next_tick;
    repeat (TickCyc) @(negedge clk);
  endtask

  task automatic do_reset;
    rst         = 1'b1;
    bus.tgt_vld = 1'b0;
    bus.stop    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    bus.stop     = 1'b0;
    bus.tgt_lft  = 11'sd300;
    bus.tgt_rght = -11'sd300;
    bus.tgt_vld  = 1'b1;
    repeat (2) @(negedge clk);
    bus.tgt_vld = 1'b0;
    rst = 1'b0;
    checks++; if (bus.lft_spd !== 11'sd0) begin errors++; $display("FAIL reset lft_spd: got %0d want 0", bus.lft_spd); end
    checks++; if (bus.rght_spd !== 11'sd0) begin errors++; $display("FAIL reset rght_spd: got %0d want 0", bus.rght_spd); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    checks++; if (bus.at_tgt !== 1'b1) begin errors++; $display("FAIL reset at_tgt: got %b want 1", bus.at_tgt); end
    repeat (3) next_tick();
    checks++; if (bus.lft_spd !== 11'sd0) begin errors++; $display("FAIL reset pending lft_spd: got %0d want 0", bus.lft_spd); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset pending busy: got %b want 0", bus.busy); end
    // Mid-ramp reset
    strobe(500, -200);
    first_tick();
    next_tick();
    checks++; if (bus.lft_spd !== 11'sd64) begin errors++; $display("FAIL midreset pre lft_spd: got %0d want 64", bus.lft_spd); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.lft_spd !== 11'sd0) begin errors++; $display("FAIL midreset lft_spd: got %0d want 0", bus.lft_spd); end
    checks++; if (bus.rght_spd !== 11'sd0) begin errors++; $display("FAIL midreset rght_spd: got %0d want 0", bus.rght_spd); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b want 0", bus.busy); end
    checks++; if (bus.at_tgt !== 1'b1) begin errors++; $display("FAIL midreset at_tgt: got %b want 1", bus.at_tgt); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) next_tick();
    checks++; if (bus.lft_spd !== 11'sd0) begin errors++; $display("FAIL midreset after lft_spd: got %0d want 0", bus.lft_spd); end
  endtask

  task automatic test_forward;
    do_reset();
    strobe(256, 0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) first_tick(); else next_tick();
      checks++; if (bus.lft_spd !== spd_t'(32 * k)) begin errors++; $display("FAIL fwd tick %0d lft_spd: got %0d want %0d", k, bus.lft_spd, 32 * k); end
      checks++; if (bus.rght_spd !== 11'sd0) begin errors++; $display("FAIL fwd tick %0d rght_spd: got %0d want 0", k, bus.rght_spd); end
      if (k < 8) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL fwd tick %0d busy: got %b want 1", k, bus.busy); end
        checks++; if (bus.at_tgt !== 1'b0) begin errors++; $display("FAIL fwd tick %0d at_tgt: got %b want 0", k, bus.at_tgt); end
      end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fwd done busy: got %b want 0", bus.busy); end
    checks++; if (bus.at_tgt !== 1'b1) begin errors++; $display("FAIL fwd done at_tgt: got %b want 1", bus.at_tgt); end
    next_tick();
    checks++; if (bus.lft_spd !== 11'sd256) begin errors++; $display("FAIL fwd hold lft_spd: got %0d want 256", bus.lft_spd); end
  endtask

  task automatic test_non_multiple;
    int e;
    do_reset();
    strobe(1023, 0);
    for (int k = 1; k <= 33; k++) begin
      if (k == 1) first_tick(); else next_tick();
      e = (32 * k > 1023) ? 1023 : 32 * k;
      checks++; if (bus.lft_spd !== spd_t'(e)) begin errors++; $display("FAIL nonmult tick %0d lft_spd: got %0d want %0d", k, bus.lft_spd, e); end
    end
    checks++; if (bus.at_tgt !== 1'b1) begin errors++; $display("FAIL nonmult at_tgt: got %b want 1", bus.at_tgt); end
  endtask

  task automatic test_reversal;
    int e, total, hold;
`ifdef MTR_ZERO_DWELL_EN
    hold = 4;
`else
    hold = 0;
`endif
    total = 16 + hold;
    do_reset();
    strobe(256, 0);
    first_tick();
    repeat (7) next_tick();
    checks++; if (bus.lft_spd !== 11'sd256) begin errors++; $display("FAIL rev settle lft_spd: got %0d want 256", bus.lft_spd); end
    strobe(-256, 0);
    for (int k = 1; k <= total; k++) begin
      if (k == 1) first_tick(); else next_tick();
      if (k <= 8) e = 256 - 32 * k;
      else if (k <= 8 + hold) e = 0;
      else e = -32 * (k - 8 - hold);
      checks++; if (bus.lft_spd !== spd_t'(e)) begin errors++; $display("FAIL rev tick %0d lft_spd: got %0d want %0d", k, bus.lft_spd, e); end
      if (k == 10) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rev tick 10 busy: got %b want 1", bus.busy); end
      end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rev done busy: got %b want 0", bus.busy); end
    checks++; if (bus.at_tgt !== 1'b1) begin errors++; $display("FAIL rev done at_tgt: got %b want 1", bus.at_tgt); end
  endtask

  task automatic test_stop;
    int el, er;
    do_reset();
    strobe(1023, -512);
    first_tick();
    repeat (31) next_tick();
    checks++; if (bus.lft_spd !== 11'sd1023) begin errors++; $display("FAIL stop pre lft_spd: got %0d want 1023", bus.lft_spd); end
    checks++; if (bus.rght_spd !== -11'sd512) begin errors++; $display("FAIL stop pre rght_spd: got %0d want -512", bus.rght_spd); end
    bus.stop = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        // Strobe while braking must be ignored
        strobe(200, 200);
        repeat (TickCyc - 1) @(negedge clk);
      end else begin
        next_tick();
      end
      el = (1023 - 128 * k < 0) ? 0 : 1023 - 128 * k;
      er = (-512 + 128 * k > 0) ? 0 : -512 + 128 * k;
      checks++; if (bus.lft_spd !== spd_t'(el)) begin errors++; $display("FAIL stop tick %0d lft_spd: got %0d want %0d", k, bus.lft_spd, el); end
      checks++; if (bus.rght_spd !== spd_t'(er)) begin errors++; $display("FAIL stop tick %0d rght_spd: got %0d want %0d", k, bus.rght_spd, er); end
      checks++; if (bus.at_tgt !== 1'b0) begin errors++; $display("FAIL stop tick %0d at_tgt: got %b want 0", k, bus.at_tgt); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stop tick %0d busy: got %b want 1", k, bus.busy); end
    end
    repeat (2) next_tick();
    checks++; if (bus.lft_spd !== 11'sd0) begin errors++; $display("FAIL stop held lft_spd: got %0d want 0", bus.lft_spd); end
    bus.stop = 1'b0;
    repeat (2) next_tick();
    checks++; if (bus.lft_spd !== 11'sd0) begin errors++; $display("FAIL stop release lft_spd: got %0d want 0", bus.lft_spd); end
    checks++; if (bus.rght_spd !== 11'sd0) begin errors++; $display("FAIL stop release rght_spd: got %0d want 0", bus.rght_spd); end
    checks++; if (bus.at_tgt !== 1'b1) begin errors++; $display("FAIL stop release at_tgt: got %b want 1", bus.at_tgt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stop release busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_clamp;
    int e;
    do_reset();
    strobe(0, -1024);
    for (int k = 1; k <= 33; k++) begin
      if (k == 1) first_tick(); else next_tick();
      e = (-32 * k < -1023) ? -1023 : -32 * k;
      checks++; if (bus.rght_spd !== spd_t'(e)) begin errors++; $display("FAIL clamp tick %0d rght_spd: got %0d want %0d", k, bus.rght_spd, e); end
    end
    checks++; if (bus.at_tgt !== 1'b1) begin errors++; $display("FAIL clamp at_tgt: got %b want 1", bus.at_tgt); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    strobe(256, -256);
    first_tick();
    next_tick();
    checks++; if (bus.lft_spd !== 11'sd64) begin errors++; $display("FAIL b2b pre lft_spd: got %0d want 64", bus.lft_spd); end
    checks++; if (bus.rght_spd !== -11'sd64) begin errors++; $display("FAIL b2b pre rght_spd: got %0d want -64", bus.rght_spd); end
    strobe(128, 0);
    first_tick();
    checks++; if (bus.lft_spd !== 11'sd96) begin errors++; $display("FAIL b2b t1 lft_spd: got %0d want 96", bus.lft_spd); end
    checks++; if (bus.rght_spd !== -11'sd32) begin errors++; $display("FAIL b2b t1 rght_spd: got %0d want -32", bus.rght_spd); end
    next_tick();
    checks++; if (bus.lft_spd !== 11'sd128) begin errors++; $display("FAIL b2b t2 lft_spd: got %0d want 128", bus.lft_spd); end
    checks++; if (bus.rght_spd !== 11'sd0) begin errors++; $display("FAIL b2b t2 rght_spd: got %0d want 0", bus.rght_spd); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b busy: got %b want 0", bus.busy); end
    checks++; if (bus.at_tgt !== 1'b1) begin errors++; $display("FAIL b2b at_tgt: got %b want 1", bus.at_tgt); end
  endtask

  initial begin
    bus.tgt_lft  = '0;
    bus.tgt_rght = '0;
    bus.tgt_vld  = 1'b0;
    bus.stop     = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    test_reset();
    test_forward();
    test_non_multiple();
    test_reversal();
    test_stop();
    test_clamp();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
